rr_packet_arbiter: RTL and testbench

- Parametrised N-way round-robin arbiter for the mesh router output ports.
- Successor to the fixed 4-way combinational arbiter, with these additions:
  - requester count set by parameter;
  - registered priority pointer;
  - valid/ready handshake with the downstream port;
  - wormhole packet lock, so the grant holds from head flit to tail flit.
- One instance sits in front of each router output port (N = 5: N/E/S/W/local).

---
 rtl/noc_arb_pkg.sv | 16 +
 rtl/rr_packet_arbiter_if.sv | 23 ++
 rtl/rr_priority_pick.sv | 53 +++++
 rtl/rr_packet_arbiter.sv | 96 +++++++++
 tb/tb_rr_packet_arbiter.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/noc_arb_pkg.sv
// Shared types and helpers for the mesh router output-port arbiters.
package noc_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int NOC_NUM_PORTS = 5;

  // Modulo increment; never returns a value >= n.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_packet_arbiter_if.sv
// Requester/downstream handshake bundle for one router output port arbiter.
interface rr_packet_arbiter_if #(
  parameter int NUM_REQ = noc_arb_pkg::NOC_NUM_PORTS,
  parameter int IDX_W   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_last;
  logic               out_ready;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               locked;

  modport master (
    output req, req_last, out_ready,
    input  gnt_onehot, gnt_idx, gnt_valid, locked
  );

  modport slave (
    input  req, req_last, out_ready,
    output gnt_onehot, gnt_idx, gnt_valid, locked
  );
endinterface

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: the first asserted req at or after
// 'start' (wrapping) wins. start must be < N.
module rr_priority_pick #(
  parameter int N     = 5,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     win_onehot,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);
  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] req_shift;
  logic [N-1:0]   rot;
  logic [N-1:0]   first_rot;
  logic [N:0]     seen;
  logic [2*N-1:0] back_dbl;
  logic [2*N-1:0] back_shift;
  logic [IDX_W:0] pos;
  logic [IDX_W:0] sum;
  logic [IDX_W:0] wrapped;

  // Rotate so that 'start' lands on bit 0; doubling avoids a modulo on each bit.
  assign req_dbl   = {req, req};
  assign req_shift = req_dbl >> start;
  assign rot       = req_shift[N-1:0];

  assign seen[0] = 1'b0;
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_prio
      assign first_rot[gi] = rot[gi] & ~seen[gi];
      assign seen[gi+1]    = seen[gi] | rot[gi];
    end
  endgenerate

  assign any = seen[N];

  assign back_dbl   = {first_rot, first_rot};
  assign back_shift = back_dbl << start;
  assign win_onehot = back_shift[2*N-1:N];

  always_comb begin
    pos = '0;
    for (int i = 0; i < N; i++) begin
      if (first_rot[i]) pos = (IDX_W+1)'(i);
    end
    sum     = {1'b0, start} + pos;
    wrapped = (sum >= (IDX_W+1)'(N)) ? sum - (IDX_W+1)'(N) : sum;
  end

  assign win_idx = wrapped[IDX_W-1:0];
endmodule

// File: rtl/rr_packet_arbiter.sv
// N-way round-robin output-port arbiter with wormhole lock from head to tail flit.
module rr_packet_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NUM_REQ = NOC_NUM_PORTS,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  rr_packet_arbiter_if.slave  arb
);
  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

  logic [IDX_W-1:0]   start_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  logic [NUM_REQ-1:0] gnt_onehot_c;
  logic [IDX_W-1:0]   gnt_idx_c;
  logic               gnt_valid_c;
  logic               xfer;

  assign start_idx = IDX_W'(next_idx(32'(ptr_q), NUM_REQ));

  rr_priority_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (arb.req),
    .start      (start_idx),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .any        (pick_any)
  );

  // Grant is combinational so a flit can move in the same cycle it is requested.
  always_comb begin
    gnt_onehot_c = '0;
    gnt_idx_c    = '0;
    gnt_valid_c  = 1'b0;
    if (state_q == ARB_LOCKED) begin
      gnt_onehot_c[lock_idx_q] = 1'b1;
      gnt_idx_c                = lock_idx_q;
      gnt_valid_c              = arb.req[lock_idx_q];
    end else begin
      gnt_onehot_c = pick_onehot;
      gnt_idx_c    = pick_idx;
      gnt_valid_c  = pick_any;
    end
    if (reset) begin
      gnt_onehot_c = '0;
      gnt_idx_c    = '0;
      gnt_valid_c  = 1'b0;
    end
  end

  assign xfer = gnt_valid_c & arb.out_ready;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_idx_d = lock_idx_q;
    if (xfer) begin
      if (state_q == ARB_IDLE) begin
        ptr_d = pick_idx;
        if (!arb.req_last[pick_idx]) begin
          state_d    = ARB_LOCKED;
          lock_idx_d = pick_idx;
        end
      end else if (arb.req_last[lock_idx_q]) begin
        // ptr was set to the owner when the head flit moved.
        state_d = ARB_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= IDX_W'(NUM_REQ - 1);
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  assign arb.gnt_onehot = gnt_onehot_c;
  assign arb.gnt_idx    = gnt_idx_c;
  assign arb.gnt_valid  = gnt_valid_c;
  assign arb.locked     = (state_q == ARB_LOCKED) & ~reset;
endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Randomized + directed bench for rr_packet_arbiter against a round-robin packet model.
module tb_rr_packet_arbiter;
  localparam int N = 5;
  localparam int W = $clog2(N);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rr_packet_arbiter_if #(.NUM_REQ(N)) bus ();

  rr_packet_arbiter #(.NUM_REQ(N)) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: last winner, and which requester (if any) owns the port.
  int m_ptr;
  bit m_locked;
  int m_lock;

  logic [W-1:0] dut_idx_s;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic run_cycle(input bit rst, input logic [N-1:0] r, input logic [N-1:0] last,
                           input bit rdy, output int g_idx, output bit g_xfer);
    int  idx;
    bit  valid;
    bit  has;
    logic [N-1:0] oh;
    @(posedge clk);
    #1;
    reset         = rst;
    bus.req       = r;
    bus.req_last  = last;
    bus.out_ready = rdy;
    @(negedge clk);
    idx = 0; valid = 0; has = 0;
    if (!rst) begin
      if (m_locked) begin
        idx = m_lock; has = 1; valid = r[m_lock];
      end else begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (!has && r[c]) begin
            idx = c; has = 1; valid = 1;
          end
        end
      end
    end
    oh = '0;
    if (has) oh[idx] = 1'b1;
    dut_idx_s = bus.gnt_idx;
    check_val("gnt_idx", 32'(bus.gnt_idx), 32'(idx));
    check_val("gnt_onehot", 32'(bus.gnt_onehot), 32'(oh));
    check_val("gnt_valid", 32'(bus.gnt_valid), 32'(valid));
    check_val("locked", 32'(bus.locked), 32'(m_locked && !rst));
    g_xfer = valid && rdy && !rst;
    g_idx  = idx;
    if (rst) begin
      m_ptr = N - 1; m_locked = 0; m_lock = 0;
    end else if (g_xfer) begin
      $display("xfer t=%0t idx=%0d last=%0b locked=%0b", $time, idx, last[idx], m_locked);
      if (!m_locked) begin
        m_ptr = idx;
        if (!last[idx]) begin
          m_locked = 1; m_lock = idx;
        end
      end else if (last[idx]) begin
        m_locked = 0;
      end
    end
  endtask

  int seq1[6] = '{0, 1, 2, 3, 4, 0};
  int seq3[5] = '{1, 1, 1, 3, 0};
  int left[N];
  int sent[N];
  int wait_pk[N];
  int gi;
  bit gx;
  bit rst_r;
  bit rdy_r;
  logic [N-1:0] r_r;
  logic [N-1:0] l_r;

  initial begin
    reset = 1'b1;
    bus.req = '0; bus.req_last = '0; bus.out_ready = 1'b0;
    m_ptr = N - 1; m_locked = 0; m_lock = 0;

    // Round-robin over all requesters from reset.
    run_cycle(1, '0, '0, 0, gi, gx);
    run_cycle(1, '0, '0, 0, gi, gx);
    for (int k = 0; k < 6; k++) begin
      run_cycle(0, 5'b11111, 5'b11111, 1, gi, gx);
      check_val("t1_seq", 32'(dut_idx_s), 32'(seq1[k]));
    end

    // Two requesters alternate.
    for (int k = 0; k < 4; k++) run_cycle(0, 5'b00101, 5'b11111, 1, gi, gx);

    // 3-flit packet from 1 while 0 and 3 wait.
    run_cycle(1, '0, '0, 0, gi, gx);
    run_cycle(0, 5'b00001, 5'b00001, 1, gi, gx);
    run_cycle(0, 5'b01011, 5'b01001, 1, gi, gx);
    check_val("t3_seq", 32'(dut_idx_s), 32'(seq3[0]));
    run_cycle(0, 5'b01011, 5'b01001, 1, gi, gx);
    check_val("t3_seq", 32'(dut_idx_s), 32'(seq3[1]));
    run_cycle(0, 5'b01011, 5'b01011, 1, gi, gx);
    check_val("t3_seq", 32'(dut_idx_s), 32'(seq3[2]));
    run_cycle(0, 5'b01001, 5'b01001, 1, gi, gx);
    check_val("t3_seq", 32'(dut_idx_s), 32'(seq3[3]));
    run_cycle(0, 5'b00001, 5'b00001, 1, gi, gx);
    check_val("t3_seq", 32'(dut_idx_s), 32'(seq3[4]));

    // Bubble while locked on 2; 4 must wait for the tail.
    run_cycle(1, '0, '0, 0, gi, gx);
    run_cycle(0, 5'b00100, 5'b00000, 1, gi, gx);
    run_cycle(0, 5'b10000, 5'b10000, 1, gi, gx);
    run_cycle(0, 5'b10000, 5'b10000, 1, gi, gx);
    run_cycle(0, 5'b10100, 5'b10000, 1, gi, gx);
    run_cycle(0, 5'b10100, 5'b10100, 1, gi, gx);
    run_cycle(0, 5'b10000, 5'b10000, 1, gi, gx);

    // Backpressure: winner may change while out_ready is low; ptr holds.
    run_cycle(1, '0, '0, 0, gi, gx);
    for (int k = 0; k < 3; k++) run_cycle(0, 5'b01000, 5'b11111, 0, gi, gx);
    run_cycle(0, 5'b00010, 5'b11111, 0, gi, gx);
    run_cycle(0, 5'b00010, 5'b11111, 1, gi, gx);
    run_cycle(0, 5'b11111, 5'b11111, 1, gi, gx);

    // Reset mid-packet.
    run_cycle(1, '0, '0, 0, gi, gx);
    run_cycle(0, 5'b01000, 5'b00000, 1, gi, gx);
    run_cycle(0, 5'b01000, 5'b00000, 1, gi, gx);
    run_cycle(1, 5'b01000, 5'b00000, 1, gi, gx);
    run_cycle(0, 5'b11111, 5'b11111, 1, gi, gx);

    // Random packet traffic with bubbles, backpressure and rare resets.
    run_cycle(1, '0, '0, 0, gi, gx);
    for (int i = 0; i < N; i++) begin
      left[i] = 0; sent[i] = 0; wait_pk[i] = 0;
    end
    repeat (600) begin
      rst_r = ($urandom_range(0, 149) == 0);
      rdy_r = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (left[i] == 0 && $urandom_range(0, 3) == 0) begin
          left[i] = $urandom_range(1, 4); sent[i] = 0; wait_pk[i] = 0;
        end
        r_r[i] = (left[i] > 0) && !(sent[i] > 0 && $urandom_range(0, 4) == 0);
        l_r[i] = (left[i] == 1) ? 1'b1 : (left[i] == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      run_cycle(rst_r, r_r, l_r, rdy_r, gi, gx);
      if (rst_r) begin
        for (int i = 0; i < N; i++) begin
          left[i] = 0; sent[i] = 0; wait_pk[i] = 0;
        end
      end else if (gx) begin
        if (sent[gi] == 0) check_val("fairness", 32'(wait_pk[gi] <= N - 1), 32'd1);
        if (left[gi] == 1) begin
          for (int i = 0; i < N; i++)
            if (i != gi && left[i] > 0 && sent[i] == 0) wait_pk[i]++;
        end
        left[gi]--;
        sent[gi]++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
